// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file with scoreboard.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, x0 never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    localparam int AW = addr_width(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_active_i,
    input  logic                iss_v_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                wr_v_i,
    input  logic [AW-1:0]       wr_a_i,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear so a same-cycle reissue keeps the register owned.
    always_comb begin
        pending_d = pending_q;
        if (!clr_active_i) begin
            if (wr_v_i) begin
                pending_d[wr_a_i] = 1'b0;
            end
            if (iss_v_i) begin
                pending_d[iss_rd_i] = 1'b1;
            end
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: hardware clear after reset, optional write bypass, scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    localparam int AW = addr_width(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ-1:0][AW-1:0]          ra_i,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_o,
    output logic [NUM_READ-1:0]                  busy_o,
    input  logic                                 we_i,
    input  logic [AW-1:0]                        wa_i,
    input  logic [DATA_WIDTH-1:0]                wd_i,
    input  logic                                 iss_v_i,
    input  logic [AW-1:0]                        iss_rd_i,
    output logic                                 init_done_o
);

    state_e                  state_q, state_d;
    logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
    logic                    init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     pending;
    logic                    ready;
    logic                    wr_en;
    logic                    iss_en;

    assign ready  = (state_q == READY);
    assign wr_en  = ready && we_i && (wa_i != AW'(REG_ZERO));
    assign iss_en = ready && iss_v_i && (iss_rd_i != AW'(REG_ZERO));

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        regs_d      = regs_q;
        init_done_d = ready;
        case (state_q)
            CLEAR: begin
                regs_d[clr_cnt_q] = '0;
                clr_cnt_d         = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (wr_en) begin
                    regs_d[wa_i] = wd_i;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Contents are only ever initialised by the clear walk, never by rst directly.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .clr_active_i (!ready),
        .iss_v_i      (iss_v_i),
        .iss_rd_i     (iss_rd_i),
        .wr_v_i       (we_i),
        .wr_a_i       (wa_i),
        .pending_o    (pending)
    );

    // Reads are forced to zero during clear so stale storage never leaks out.
    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            rd_o[k]   = '0;
            busy_o[k] = 1'b0;
            if (ready && (ra_i[k] != AW'(REG_ZERO))) begin
                rd_o[k]   = regs_q[ra_i[k]];
                busy_o[k] = pending[ra_i[k]];
                if ((BYPASS != 0) && wr_en && (ra_i[k] == wa_i)) begin
                    rd_o[k]   = wd_i;
                    busy_o[k] = iss_en && (iss_rd_i == wa_i);
                end
            end
        end
    end

    assign init_done_o = init_done_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Next-generation integer register file for the pipelined RISC-V core.
- Parametrised read-port count and hardwired x0.
- Hardware clear sequence after reset; optional write-to-read bypass.
- Per-register pending (scoreboard) bits: decode/hazard logic stalls on in-flight producers.
- Sits between decode (reads, issue marking) and writeback (writes, pending clear).

Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, >=2)
- NUM_READ, 2, number of independent read ports (>=1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra_i  in  NUM_READ x AW  read addresses, AW = $clog2(NUM_REGS)
- rd_o  out  NUM_READ x DATA_WIDTH  read data, combinational
- busy_o  out  NUM_READ  pending bit for each read address, combinational
- we_i  in  1  write enable (writeback)
- wa_i  in  AW  write address
- wd_i  in  DATA_WIDTH  write data
- iss_v_i  in  1  issue valid: mark iss_rd_i pending
- iss_rd_i  in  AW  destination register of issued instruction
- init_done_o  out  1  high once clear sequence complete

Behaviour:
- Reset: one clock, synchronous, active-high; clock named clk, reset named rst.
- rst high at an edge → state CLEAR, clear counter = 0, all pending bits = 0, init_done_o = 0.
- CLEAR state:
  - Each cycle writes 0 to regs[counter], counter++.
  - After the write of index NUM_REGS-1 → READY.
  - init_done_o rises exactly NUM_REGS cycles after the first edge with rst low.
- During CLEAR:
  - rd_o = 0, busy_o = 0.
  - we_i and iss_v_i are ignored (no write, no pending set).
- READY state: stays until rst. rst mid-operation, in either state, restarts CLEAR from index 0 and drops all pending bits.
- Write (READY):
  - we_i=1 and wa_i!=0 → regs[wa_i] <= wd_i at the edge.
  - The same write also clears pending[wa_i].
- Issue (READY):
  - iss_v_i=1 and iss_rd_i!=0 → pending[iss_rd_i] <= 1.
  - Same-cycle issue and write to the same address: set wins (new producer owns register), data still written.
- x0: reads always 0, busy always 0, writes and issues to address 0 ignored.
- Read, BYPASS=1:
  - ra_i[k] == wa_i with we_i=1 and wa_i!=0 → rd_o[k] = wd_i.
  - busy_o[k] = 0 unless the same cycle also issues to that address.
- Read, BYPASS=0: rd_o[k] = stored value; busy_o[k] = stored pending bit.
- All read ports are independent; same address on several ports gives identical results.
- No reset of register contents other than through CLEAR; no X reaches rd_o after init_done_o.

Decomposition:
- Package regfile_pkg holds:
  - state enum {CLEAR, READY}
  - localparam AW = $clog2(NUM_REGS) helper
  - zero-register index constant REG_ZERO = 0
- One sub-module, regfile_scoreboard:
  - Holds the NUM_REGS pending vector, set/clear priority and x0 masking.
  - Inputs: clk, rst, clear-active, issue and write strobes.
  - Outputs: pending vector.
- Storage array, clear FSM/counter and bypass muxes stay in regfile_sb.

Test Plan:
- Clear sequence: NUM_REGS=32, rst high 2 cycles then low → init_done_o=0 for 32 cycles, =1 on 33rd; every register reads 0; we_i=1 wa=5 wd=0xDEAD during CLEAR leaves x5=0.
- Basic write/read: write x7=0x12345678, next cycle ra_i[0]=7 → rd_o[0]=0x12345678; write x0=0xFFFFFFFF → ra=0 returns 0.
- Bypass: BYPASS=1, same cycle we_i=1 wa=3 wd=0xA5A5A5A5 and ra_i[1]=3 → rd_o[1]=0xA5A5A5A5; with BYPASS=0 → rd_o[1] returns old x3 until next cycle.
- Scoreboard: issue rd=9 → next cycle busy_o=1 for ra=9; write x9 → busy 0 after edge (0 in same cycle with BYPASS=1); simultaneous issue rd=9 and write x9 → pending stays 1.
- Reset mid-run: x4 pending and x4=0x55, assert rst 1 cycle → pending clear, CLEAR restarts, after 32 cycles x4 reads 0, busy 0.
- Multi-port: NUM_READ=3, all three ports ra=x4 after write 0x77 → all rd_o=0x77.
